seq_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor for the shift-and-add multiplier datapath and its successors. It is the next generation of the team's 16-bit ripple-carry adder. Width and per-cycle slice width are generic, and it adds a subtract mode, a signed-overflow flag and a start/done handshake. It processes one CHUNK-bit slice per clock through a narrow ripple adder with a registered carry, which trades latency for area and critical-path length.

---
 rtl/addsub_pkg.sv | 22 ++
 rtl/seq_addsub_if.sv | 24 ++
 rtl/seq_addsub_chunk_adder.sv | 26 ++
 rtl/seq_addsub.sv | 121 ++++++++++++
 tb/tb_seq_addsub.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slice index needs at least one bit even when the whole word is one slice.
  function automatic int idx_w_f(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Start/done handshake and operand/result bus of the sequential adder/subtractor.
interface seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_addsub_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the caller can derive two's-complement overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign co   = c_s[CHUNK];
  assign cmsb = c_s[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock through a narrow
// ripple adder with a registered carry; start/done handshake on the bus.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst_n,
  seq_addsub_if.slave bus
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w_f(NCHUNK);

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  state_e             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   part_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;

  logic [CHUNK-1:0]   slice_a_s;
  logic [CHUNK-1:0]   slice_b_s;
  logic [CHUNK-1:0]   slice_sum_s;
  logic               slice_co_s;
  logic               slice_cm_s;
  logic               last_s;
  logic [WIDTH-1:0]   full_s;

  assign slice_a_s = opa_r[int'(idx_r)*CHUNK +: CHUNK];
  assign slice_b_s = opb_r[int'(idx_r)*CHUNK +: CHUNK];
  assign last_s    = (idx_r == IDX_W'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .ci   (carry_r),
    .s    (slice_sum_s),
    .co   (slice_co_s),
    .cmsb (slice_cm_s)
  );

  // Partial sum with the slice being computed this cycle merged in.
  always_comb begin
    full_s = part_r;
    full_s[int'(idx_r)*CHUNK +: CHUNK] = slice_sum_s;
  end

  // Control FSM, slice datapath registers and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      opa_r   <= '0;
      opb_r   <= '0;
      part_r  <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            opa_r   <= bus.a;
            opb_r   <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            carry_r <= bus.sub;
            idx_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          part_r[int'(idx_r)*CHUNK +: CHUNK] <= slice_sum_s;
          carry_r <= slice_co_s;
          if (last_s) begin
            // Results move only here, so they hold through the next RUN.
            sum_r   <= full_s;
            cout_r  <= slice_co_s;
            ovf_r   <= slice_co_s ^ slice_cm_s;
            idx_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          idx_r   <= '0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: CHUNK=4 and CHUNK=16 instances, results
// checked against an arithmetic model when done pulses.
module tb_seq_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q0[$];
  res_t q1[$];
  res_t r0, r1;
  res_t prev0;

  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(16)) bus0 ();
  seq_addsub_if #(.WIDTH(16)) bus1 ();

  seq_addsub #(.WIDTH(16), .CHUNK(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic s, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] r;
    res_t o;
    if (!s) begin
      r      = {1'b0, x} + {1'b0, y};
      o.cout = r[16];
      o.ovf  = (x[15] == y[15]) && (r[15] != x[15]);
    end else begin
      r      = {1'b0, x} - {1'b0, y};
      o.cout = (x >= y);
      o.ovf  = (x[15] != y[15]) && (r[15] != x[15]);
    end
    o.sum = r[15:0];
    return o;
  endfunction

  // Scoreboard pop/compare for both instances.
  always @(negedge clk) begin
    if (bus0.done) begin
      if (q0.size() == 0) check("unexpected_done0", 32'd1, 32'd0);
      else begin
        r0 = q0.pop_front();
        check("sum0",  {16'd0, bus0.sum}, {16'd0, r0.sum});
        check("cout0", {31'd0, bus0.cout}, {31'd0, r0.cout});
        check("ovf0",  {31'd0, bus0.ovf},  {31'd0, r0.ovf});
      end
    end
    if (bus1.done) begin
      if (q1.size() == 0) check("unexpected_done1", 32'd1, 32'd0);
      else begin
        r1 = q1.pop_front();
        check("sum1",  {16'd0, bus1.sum}, {16'd0, r1.sum});
        check("cout1", {31'd0, bus1.cout}, {31'd0, r1.cout});
        check("ovf1",  {31'd0, bus1.ovf},  {31'd0, r1.ovf});
      end
    end
  end

  task automatic issue0(input logic s, input logic [15:0] x, input logic [15:0] y);
    bus0.start = 1'b1;
    bus0.sub   = s;
    bus0.a     = x;
    bus0.b     = y;
    q0.push_back(model(s, x, y));
  endtask

  // Counts negedges from issue until done; cyc=5 means done 4 cycles after the start edge.
  task automatic wait_done0(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus0.start = 1'b0;
      cyc++;
      if (bus0.busy) bcnt++;
      if (bus0.done) break;
    end
    if (!bus0.done) check("timeout0", 32'd0, 32'd1);
  endtask

  task automatic op0(input logic s, input logic [15:0] x, input logic [15:0] y);
    int cyc, bcnt;
    @(negedge clk);
    issue0(s, x, y);
    prev0 = model(s, x, y);
    wait_done0(cyc, bcnt);
    check("latency0", 32'(cyc - 1), 32'd4);
    check("busy_cycles0", 32'(bcnt), 32'd4);
  endtask

  initial begin
    int cyc, bcnt;
    logic [15:0] held;
    rst_n = 1'b0;
    bus0.start = 1'b0; bus0.sub = 1'b0; bus0.a = 16'd0; bus0.b = 16'd0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = 16'd0; bus1.b = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus0.busy}, 32'd0);
    check("rst_done", {31'd0, bus0.done}, 32'd0);
    check("rst_sum",  {16'd0, bus0.sum},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    op0(1'b0, 16'h1234, 16'h0FED);
    op0(1'b0, 16'hFFFF, 16'h0001);
    op0(1'b0, 16'h7FFF, 16'h0001);
    op0(1'b1, 16'h0005, 16'h0007);
    op0(1'b1, 16'h8000, 16'h0001);
    for (int k = 0; k < 4; k++)
      op0(1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));

    // New operands pulsed mid-RUN must be ignored; old result must hold meanwhile.
    held = prev0.sum;
    @(negedge clk);
    issue0(1'b0, 16'h1111, 16'h2222);
    prev0 = model(1'b0, 16'h1111, 16'h2222);
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    bus0.start = 1'b1; bus0.sub = 1'b1; bus0.a = 16'hFFFF; bus0.b = 16'h0F0F;
    check("hold_sum", {16'd0, bus0.sum}, {16'd0, held});
    @(negedge clk);
    bus0.start = 1'b0;
    cyc = 3;
    while (!bus0.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("midrun_latency", 32'(cyc - 1), 32'd4);

    // Start held in the DONE cycle is accepted back-to-back.
    issue0(1'b1, 16'h4000, 16'h0123);
    wait_done0(cyc, bcnt);
    check("b2b_gap", 32'(cyc), 32'd5);
    check("b2b_busy", 32'(bcnt), 32'd4);

    // Reset in the second RUN cycle aborts without a done.
    @(negedge clk);
    bus0.start = 1'b1; bus0.sub = 1'b0; bus0.a = 16'h0F0F; bus0.b = 16'h0101;
    @(negedge clk);
    bus0.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus0.busy}, 32'd0);
    check("abort_done", {31'd0, bus0.done}, 32'd0);
    check("abort_sum",  {16'd0, bus0.sum},  32'd0);
    check("abort_cout", {31'd0, bus0.cout}, 32'd0);
    check("abort_ovf",  {31'd0, bus0.ovf},  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_idle", {31'd0, bus0.busy}, 32'd0);
    op0(1'b0, 16'h0F0F, 16'h0101);

    // Single-slice instance: done one cycle after the start edge.
    @(negedge clk);
    bus1.start = 1'b1; bus1.sub = 1'b0; bus1.a = 16'hABCD; bus1.b = 16'h1111;
    q1.push_back(model(1'b0, 16'hABCD, 16'h1111));
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus1.start = 1'b0;
      cyc++;
      if (bus1.done) break;
    end
    check("latency1", 32'(cyc - 1), 32'd1);
    check("sum1_const", {16'd0, bus1.sum}, 32'h0000BCDE);

    repeat (3) @(negedge clk);
    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
